// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg -- MEM/WB pipeline register with write-back mux,
// WB-to-EX forwarding compare and a consecutive-stall counter.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   hit                 : data-cache hit; 0 stalls MEM, so the register holds
//   flush               : squash the instruction entering WB (bubble in)
//   valid_in            : MEM holds a real instruction
//   read_data,
//   alu_result          : load data / ALU result from MEM
//   write_reg           : destination register
//   reg_write,
//   mem_to_reg          : write-back control
//   rs, rt              : EX-stage sources for the forwarding compare
//   *_out, valid_out    : registered stage contents
//   wb_data             : selected write-back value (combinational)
//   fwd_rs, fwd_rt      : WB-to-EX forwarding hit (combinational)
//   stall_cycles        : current consecutive-stall length, saturating
module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_AW-1:0] write_reg,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_AW-1:0] write_reg_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_rs,
  output logic              fwd_rt,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int STAGES = 1;

  // Data payload: held on stall and on flush.
  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] write_reg;
  } wb_data_t;

  // Control payload: cleared on flush so a squashed slot never commits.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  wb_data_t          data_d, data_q;
  wb_ctrl_t          ctrl_d, ctrl_q;
  logic [STAGES:0]   vld_pipe;
  logic [CNT_W-1:0]  stall_q;

  // vld_pipe[0] is the MEM-side valid, vld_pipe[STAGES] the WB-side one.
  assign vld_pipe[0] = valid_in;

  always_comb begin
    data_d.read_data  = read_data;
    data_d.alu_result = alu_result;
    data_d.write_reg  = write_reg;
    // Bubbles and writes to r0 are dropped here, so nothing downstream
    // (including the forwarding compare) needs to re-check them.
    ctrl_d.reg_write  = reg_write & valid_in & (write_reg != '0);
    ctrl_d.mem_to_reg = mem_to_reg;
  end

  // Stage registers. Flush wins over the stall hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q             <= '0;
      ctrl_q             <= '0;
      vld_pipe[STAGES]   <= 1'b0;
    end else if (flush) begin
      ctrl_q             <= '0;
      vld_pipe[STAGES]   <= 1'b0;
    end else if (hit) begin
      data_q             <= data_d;
      ctrl_q             <= ctrl_d;
      vld_pipe[STAGES]   <= vld_pipe[0];
    end
  end

  // Stall counter: independent of flush; any hit edge restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (hit)
      stall_q <= '0;
    else if (!(&stall_q))
      stall_q <= stall_q + 1'b1;
  end

  assign read_data_out  = data_q.read_data;
  assign alu_result_out = data_q.alu_result;
  assign write_reg_out  = data_q.write_reg;
  assign reg_write_out  = ctrl_q.reg_write;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;
  assign valid_out      = vld_pipe[STAGES];
  assign stall_cycles   = stall_q;

  assign wb_data = ctrl_q.mem_to_reg ? data_q.read_data : data_q.alu_result;

  // rs/rt == 0 never forwards: r0 is hardwired zero.
  assign fwd_rs = ctrl_q.reg_write && (data_q.write_reg == rs) && (rs != '0);
  assign fwd_rt = ctrl_q.reg_write && (data_q.write_reg == rt) && (rt != '0);

endmodule
